// File: rtl/smu_uart_pkg.sv
// Shared definitions for the smu_uart MMIO peripheral: register offsets,
// STATUS bit positions and the TX/RX state encodings.
package smu_uart_pkg;

  localparam logic [3:0] UART_DATA_OFS = 4'h0;
  localparam logic [3:0] UART_STAT_OFS = 4'h4;

  localparam int STAT_TX_BUSY   = 0;
  localparam int STAT_RX_VALID  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/smu_uart_baud_cnt.sv
// Loadable down-counter for bit timing; tc pulses while enabled at zero.
module smu_uart_baud_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Reload has priority; the count parks at zero until the next reload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/smu_uart_mmio.sv
// Memory-mapped 8N1 UART with combinational read data.
// Build option: SMU_UART_LOOPBACK_EN feeds uart_txd back into the receiver.
module smu_uart_mmio
  import smu_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cs_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [1:0] IDX_DATA = UART_DATA_OFS[3:2];
  localparam logic [1:0] IDX_STAT = UART_STAT_OFS[3:2];

  logic sel_data_s, sel_stat_s, tx_wr_s, stat_wr_s, rd_clr_s, tx_accept_s;

  tx_state_e  tx_state_r, tx_state_nxt_s;
  logic [2:0] tx_bit_r, tx_bit_nxt_s;
  logic [7:0] tx_data_r;
  logic       uart_txd_r, txd_nxt_s, tx_load_s, tx_tc_s, tx_busy_s;

  rx_state_e  rx_state_r, rx_state_nxt_s;
  logic [2:0] rx_bit_r, rx_bit_nxt_s;
  logic [7:0] rx_shift_r, rx_shift_nxt_s;
  logic       rx_sync1_r, rx_sync2_r, rx_prev_r, rx_fall_s, rx_pin_s;
  logic       rx_load_s, rx_tc_s, byte_done_s, frame_bad_s;
  logic [CNT_W-1:0] rx_load_val_s;

  logic [7:0] rx_byte_r;
  logic       rx_valid_r, overrun_r, frame_err_r;
  logic       unused_bits_s;

  assign sel_data_s  = !cs_n && (addr[3:2] == IDX_DATA);
  assign sel_stat_s  = !cs_n && (addr[3:2] == IDX_STAT);
  assign tx_wr_s     = sel_data_s && we && be[0];
  assign stat_wr_s   = sel_stat_s && we && be[0];
  assign rd_clr_s    = sel_data_s && re;
  assign tx_accept_s = tx_wr_s && (tx_state_r == TX_IDLE);
  assign tx_busy_s   = (tx_state_r != TX_IDLE);
  assign uart_txd    = uart_txd_r;

`ifdef SMU_UART_LOOPBACK_EN
  assign rx_pin_s      = uart_txd_r;
  assign unused_bits_s = ^{addr[1:0], wdata[31:8], be[3:1], uart_rxd};
`else
  assign rx_pin_s      = uart_rxd;
  assign unused_bits_s = ^{addr[1:0], wdata[31:8], be[3:1]};
`endif

  smu_uart_baud_cnt #(.W(CNT_W)) u_tx_baud (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (tx_busy_s),
    .load     (tx_load_s),
    .load_val (BIT_LOAD),
    .tc       (tx_tc_s)
  );

  smu_uart_baud_cnt #(.W(CNT_W)) u_rx_baud (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (rx_state_r != RX_IDLE),
    .load     (rx_load_s),
    .load_val (rx_load_val_s),
    .tc       (rx_tc_s)
  );

  // TX state register and datapath; the line is driven from a flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_r <= TX_IDLE;
      tx_bit_r   <= 3'd0;
      tx_data_r  <= 8'h00;
      uart_txd_r <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      uart_txd_r <= txd_nxt_s;
      if (tx_accept_s) begin
        tx_data_r <= wdata[7:0];
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  // TX next state; writes arriving while busy are simply not seen here.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_bit_nxt_s   = tx_bit_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_wr_s) tx_state_nxt_s = TX_START;
        else         tx_state_nxt_s = TX_IDLE;
      end
      TX_START: begin
        tx_bit_nxt_s = 3'd0;
        if (tx_tc_s) tx_state_nxt_s = TX_DATA;
        else         tx_state_nxt_s = TX_START;
      end
      TX_DATA: begin
        if (tx_tc_s) begin
          tx_bit_nxt_s = tx_bit_r + 3'd1;
          if (tx_bit_r == 3'd7) tx_state_nxt_s = TX_STOP;
          else                  tx_state_nxt_s = TX_DATA;
        end else begin
          tx_state_nxt_s = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_tc_s) tx_state_nxt_s = TX_IDLE;
        else         tx_state_nxt_s = TX_STOP;
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
        tx_bit_nxt_s   = 3'd0;
      end
    endcase
  end

  // TX outputs, computed from the next state so the line flop changes with it.
  always_comb begin
    txd_nxt_s = 1'b1;
    if (tx_state_r == TX_IDLE) tx_load_s = tx_wr_s;
    else                       tx_load_s = tx_tc_s;
    case (tx_state_nxt_s)
      TX_START: txd_nxt_s = 1'b0;
      TX_DATA:  txd_nxt_s = tx_data_r[tx_bit_nxt_s];
      default:  txd_nxt_s = 1'b1;
    endcase
  end

  // RX synchroniser, edge-detect history and state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_sync1_r <= rx_pin_s;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
      rx_state_r <= rx_state_nxt_s;
      rx_bit_r   <= rx_bit_nxt_s;
      rx_shift_r <= rx_shift_nxt_s;
    end
  end

  assign rx_fall_s = rx_prev_r && !rx_sync2_r;

  // RX next state; a high line at the mid-start sample is treated as a glitch.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_bit_nxt_s   = rx_bit_r;
    rx_shift_nxt_s = rx_shift_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) rx_state_nxt_s = RX_START;
        else           rx_state_nxt_s = RX_IDLE;
      end
      RX_START: begin
        rx_bit_nxt_s = 3'd0;
        if (rx_tc_s) rx_state_nxt_s = rx_sync2_r ? RX_IDLE : RX_DATA;
        else         rx_state_nxt_s = RX_START;
      end
      RX_DATA: begin
        if (rx_tc_s) begin
          rx_shift_nxt_s = {rx_sync2_r, rx_shift_r[7:1]};
          rx_bit_nxt_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_nxt_s = RX_STOP;
          else                  rx_state_nxt_s = RX_DATA;
        end else begin
          rx_state_nxt_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_tc_s) rx_state_nxt_s = RX_IDLE;
        else         rx_state_nxt_s = RX_STOP;
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
        rx_bit_nxt_s   = 3'd0;
      end
    endcase
  end

  // RX outputs: counter reload and end-of-frame events.
  always_comb begin
    if (rx_state_r == RX_IDLE) begin
      rx_load_s     = rx_fall_s;
      rx_load_val_s = HALF_LOAD;
    end else begin
      rx_load_s     = rx_tc_s;
      rx_load_val_s = BIT_LOAD;
    end
    byte_done_s = (rx_state_r == RX_STOP) && rx_tc_s && rx_sync2_r;
    frame_bad_s = (rx_state_r == RX_STOP) && rx_tc_s && !rx_sync2_r;
  end

  // Receive buffer and sticky flags; a DATA read coinciding with a new byte frees the slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_byte_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (byte_done_s && (!rx_valid_r || rd_clr_s)) begin
        rx_byte_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rd_clr_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      if (byte_done_s && rx_valid_r && !rd_clr_s) begin
        overrun_r <= 1'b1;
      end else if (stat_wr_s && wdata[STAT_OVERRUN]) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (frame_bad_s) begin
        frame_err_r <= 1'b1;
      end else if (stat_wr_s && wdata[STAT_FRAME_ERR]) begin
        frame_err_r <= 1'b0;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rdata = 32'h0000_0000;
    if (!cs_n) begin
      case (addr[3:2])
        IDX_DATA: rdata = {24'h00_0000, rx_byte_r};
        IDX_STAT: rdata = {28'h000_0000, frame_err_r, overrun_r, rx_valid_r, tx_busy_s};
        default:  rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_smu_uart_mmio.sv
// Self-checking bench for smu_uart_mmio at 16 clocks per bit, with a
// frame-level reference model of the receive buffer and status flags.
module tb_smu_uart_mmio;

  logic        clk = 1'b0;
  logic        n_rst, cs_n, we, re;
  logic [3:0]  addr, be;
  logic [31:0] wdata, rdata;
  logic        uart_txd, uart_rxd;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model of the receive side
  logic [7:0] m_byte;
  logic       m_valid, m_ovr, m_err;

  always #5 clk = ~clk;

  smu_uart_mmio #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .cs_n     (cs_n),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .rdata    (rdata),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  function automatic logic [31:0] exp_status();
    return {28'h0, m_err, m_ovr, m_valid, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_peek(input logic [3:0] a);
    cs_n = 1'b0; we = 1'b0; re = 1'b0; addr = a; wdata = 32'h0; be = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    cs_n = 1'b0; we = 1'b0; re = 1'b1; addr = a; be = 4'h0;
    #1 d = rdata;
    @(posedge clk); #1;
    set_peek(4'h4); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs_n = 1'b0; we = 1'b1; re = 1'b0; addr = a; wdata = d; be = 4'h1;
    @(posedge clk); #1;
    set_peek(4'h4); #1;
  endtask

  // Send one byte and compare the line and busy flag on every clock of the frame.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    cs_n = 1'b0; we = 1'b1; re = 1'b0; addr = 4'h0; wdata = {24'h0, b}; be = 4'h1;
    @(posedge clk); #1;
    set_peek(4'h4); #1;
    for (int c = 0; c <= 160; c++) begin
      check("tx_txd", {31'h0, uart_txd}, {31'h0, (c < 160) ? frame[c/16] : 1'b1});
      check("tx_busy", {31'h0, rdata[0]}, {31'h0, (c < 160) ? 1'b1 : 1'b0});
      if (c < 160) begin
        if (inject && c == 40) begin
          we = 1'b1; addr = 4'h0; wdata = 32'h3C; be = 4'h1;
        end
        @(posedge clk); #1;
        set_peek(4'h4); #1;
      end
    end
  endtask

  // Drive one frame on uart_rxd; check STATUS one clock before and at the expected completion.
  task automatic rx_send(input logic [7:0] b, input logic stop, input bit rd_at_done);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    set_peek(4'h4);
    uart_rxd = frame[0];
    #1;
    for (int k = 1; k <= 160; k++) begin
      @(posedge clk); #1;
      uart_rxd = (k < 160) ? frame[k/16] : 1'b1;
      #1;
      if (k == 154) begin
        check("rx_status_before", rdata, exp_status());
        if (rd_at_done) begin
          re = 1'b1; addr = 4'h0;
          #1 check("rx_read_at_done", rdata, {24'h0, m_byte});
        end
      end
      if (k == 155) begin
        if (rd_at_done) begin
          set_peek(4'h4); #1;
        end
        if (stop) begin
          if (!m_valid || rd_at_done) begin
            m_byte  = b;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_err = 1'b1;
          if (rd_at_done) m_valid = 1'b0;
        end
        check("rx_status_done", rdata, exp_status());
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  r;
    n_rst = 1'b0; uart_rxd = 1'b1;
    cs_n = 1'b1; we = 1'b0; re = 1'b0; addr = 4'h4; wdata = 32'h0; be = 4'h0;
    m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_txd", {31'h0, uart_txd}, 32'h1);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    check("deselect_rdata", rdata, 32'h0);
    rd(4'h4, d); check("reset_status", d, 32'h0);
    set_peek(4'h0); #1 check("reset_data", rdata, 32'h0);
    check("reset_txd_after", {31'h0, uart_txd}, 32'h1);

    // 0xA5 frame with a dropped write while busy, then confirm the line stays idle
    tx_frame(8'hA5, 1'b1);
    for (int i = 0; i < 200; i++) begin
      check("no_second_frame", {30'h0, uart_txd, rdata[0]}, 32'h2);
      @(posedge clk); #1;
    end
    tx_frame(8'($urandom_range(0, 255)), 1'b0);
    tx_frame(8'($urandom_range(0, 255)), 1'b0);

    // single byte, read clears rx_valid
    rx_send(8'h5A, 1'b1, 1'b0);
    rd(4'h0, d); check("rx_data_5a", d, 32'h5A);
    m_valid = 1'b0;
    rd(4'h4, d); check("status_after_read", d, exp_status());
    cs_n = 1'b1; addr = 4'h0; #1 check("deselect_data", rdata, 32'h0);

    // overrun keeps the first byte
    rx_send(8'h11, 1'b1, 1'b0);
    rx_send(8'h22, 1'b1, 1'b0);
    rd(4'h4, d); check("status_overrun", d, exp_status());
    wr(4'h4, 32'h4); m_ovr = 1'b0;
    rd(4'h4, d); check("status_ovr_cleared", d, exp_status());
    rd(4'h0, d); check("rx_data_11", d, {24'h0, m_byte});
    m_valid = 1'b0;
    rd(4'h4, d); check("status_empty", d, exp_status());

    // framing error, then a short glitch that must be ignored
    rx_send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    rd(4'h4, d); check("status_frame_err", d, exp_status());
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("glitch_status", rdata, exp_status());
    set_peek(4'h0); #1 check("glitch_data", rdata, {24'h0, m_byte});
    wr(4'h4, 32'h8); m_err = 1'b0;
    rd(4'h4, d); check("status_err_cleared", d, exp_status());

    // read of DATA in the very cycle a new byte lands, then random traffic
    rx_send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    rx_send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    rd(4'h0, d); check("rx_data_same_cycle", d, {24'h0, m_byte});
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      rx_send(r, 1'b1, 1'b0);
      rd(4'h0, d); check("rx_data_random", d, {24'h0, r});
      m_valid = 1'b0;
      rd(4'h4, d); check("rx_status_random", d, exp_status());
    end

    // reset in the middle of a transmission forces the line high at once
    wr(4'h0, 32'h00);
    repeat (30) @(posedge clk);
    #2 check("mid_frame_txd", {31'h0, uart_txd}, 32'h0);
    #1 n_rst = 1'b0;
    #1 check("async_reset_txd", {31'h0, uart_txd}, 32'h1);
    m_byte = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_err = 1'b0;
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("post_reset_txd", {31'h0, uart_txd}, 32'h1);
    check("post_reset_status", rdata, exp_status());
    set_peek(4'h0); #1 check("post_reset_data", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/smu_uart_mmio.md
# smu_uart_mmio

Memory-mapped UART peripheral on the RV32I data bus, selected by the system's `cs_uart_n` decode and driving/receiving the board `UART_TXD`/`UART_RXD` pins. It converts CPU stores into 8N1 serial frames and deserialises incoming frames into a one-byte receive buffer. The CPU polls a status register to use it. Read data is combinational, matching the asynchronous-read data memory, so the single-cycle core can consume it in the same cycle.

## Interface
Parameters:
- `CLOCK_FREQ`, default 125_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: serial bit rate.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `n_rst`  in  1: reset; asynchronous, active-low.
- `cs_n`  in  1: peripheral select, active-low.
- `we`  in  1: store strobe.
- `re`  in  1: load strobe.
- `addr`  in  4: byte offset; only `addr[3:2]` is decoded.
- `wdata`  in  32: store data.
- `be`  in  4: byte enables; only `be[0]` is honoured.
- `rdata`  out  32: load data, combinational.
- `uart_txd`  out  1: serial output, idle high.
- `uart_rxd`  in  1: serial input, asynchronous.

## Operation
- `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE`, using integer truncation. `HALF_BIT = CLKS_PER_BIT / 2`.
- Register map:
  - 0x0 DATA:
    - Write with `be[0]`: loads `wdata[7:0]` into TX.
    - Read: `{24'b0, rx_byte}`.
  - 0x4 STATUS, read: `{28'b0, frame_err, overrun, rx_valid, tx_busy}`. Writing 1 to bit 2 clears `overrun`; writing 1 to bit 3 clears `frame_err`.
  - 0x8 and 0xC: read 0; writes are ignored.
- An access happens only when `cs_n`=0. `rdata` is 0 when `cs_n`=1.
- TX FSM:
  - States IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state lasts `CLKS_PER_BIT` clocks. A bit counter of 0–7 runs in DATA.
  - `tx_busy` is 1 in every state except IDLE.
  - A DATA write while `tx_busy`=1 is dropped silently.
- RX path:
  - `uart_rxd` passes through a 2-flop synchroniser; the reset value of both flops is 1.
  - RX FSM states IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised 1→0 transition.
  - START: sample at `HALF_BIT`. If the sample is 1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: sample every `CLKS_PER_BIT` clocks, 8 bits, LSB first.
  - STOP: sample after `CLKS_PER_BIT`.
    - If the stop bit is 0: set `frame_err` and discard the byte.
    - If the stop bit is 1 and `rx_valid`=0: load `rx_byte` and set `rx_valid`.
    - If the stop bit is 1 and `rx_valid`=1: keep the old `rx_byte` and set `overrun`.
  - The FSM returns to IDLE in all three cases.
- A read of DATA with `re`=1 clears `rx_valid` at the next edge.
- Simultaneous events:
  - A DATA read in the same cycle a new byte completes: the new byte loads, `rx_valid` stays 1, and `overrun` is not set.
  - A STATUS clear in the same cycle as a new error event: the set wins.

## Timing
- Reset values:
  - `uart_txd`=1.
  - `tx_busy`, `rx_valid`, `overrun`, `frame_err` = 0.
  - `rx_byte` = 0.
  - Both FSMs in IDLE.
  - `rdata` follows the combinational decode.
- An asserted reset in mid-frame aborts immediately. `uart_txd` returns to 1 asynchronously.
- TX:
  - A write accepted at edge N drives `uart_txd`=0 from edge N.
  - `tx_busy` reads 1 in the cycle after edge N.
  - The frame occupies exactly `10*CLKS_PER_BIT` clocks.
  - `tx_busy` falls at the end of the stop bit; a new write is accepted in that same cycle.
- RX:
  - Latency from the start-bit falling edge at the pin to `rx_valid`=1 is 2 synchroniser clocks + `HALF_BIT` + `9*CLKS_PER_BIT` + 1 clock.
- The read side effect (clearing `rx_valid`) takes place on the edge that ends the load cycle, so the data returned in that cycle is the old value.

## Configuration
- `SMU_UART_LOOPBACK_EN`:
  - Defined: the RX synchroniser input is `uart_txd` instead of `uart_rxd`, and `uart_rxd` is ignored. This is for board self-test.
  - Undefined: RX uses `uart_rxd`, which is the normal behaviour.

## Structure
- A shared package `smu_uart_pkg` holds:
  - The register offset constants `UART_DATA_OFS`=0x0 and `UART_STAT_OFS`=0x4.
  - The STATUS bit index constants.
  - The TX/RX state typedefs.
- One sub-module, `smu_uart_baud_cnt`: a loadable down-counter with a terminal-count pulse. It is instantiated once for TX and once for RX; RX loads `HALF_BIT` for the start-bit sample.
- The register decode and the read mux live in the top module.

## Test plan
Benches use `CLOCK_FREQ`=16 and `BAUD_RATE`=1, so `CLKS_PER_BIT`=16 and `HALF_BIT`=8.
- Reset, then read STATUS → 0x0. `uart_txd`=1.
- Write 0xA5 to DATA → `uart_txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks. `tx_busy`=1 for 160 clocks.
- Write 0x3C while busy, then wait → only the first byte appears. No second frame starts.
- Drive a 0x5A frame on `uart_rxd` → `rx_valid`=1 and DATA reads 0x5A. The next STATUS read shows `rx_valid`=0.
- Receive 0x11 then 0x22 without reading → DATA reads 0x11 and STATUS = 0x6. Write 0x4 to STATUS → 0x2.
- Stop bit driven 0 → STATUS bit 3 set and `rx_valid`=0. Apply a 4-clock low glitch on `uart_rxd` → no state change.
